wb_phyf_writer: RTL

//   Write-back collector on the write side of phy_regfile.
//   - Accepts results from EXE_UNIT_NUM execute units through valid/ready handshakes.
//   - Buffers them in per-unit FIFOs.
//   - Each cycle, round-robin arbitrates up to WB_WIDTH results onto the registered
//     wb_phyf_id/wb_phyf_data/wb_phyf_we write lanes.
//   - A commit flush discards all buffered results.

---
 rtl/wb_phyf_writer.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/wb_phyf_writer.sv
// Write-back collector: per-unit result FIFOs feeding up to WB_WIDTH registered
// phy_regfile write lanes through a rotating-priority arbiter.
module wb_phyf_writer #(
  parameter int unsigned EXE_UNIT_NUM     = 6,
  parameter int unsigned WB_WIDTH         = 4,
  parameter int unsigned FIFO_DEPTH       = 2,
  parameter int unsigned PHY_REG_ID_WIDTH = 6,
  parameter int unsigned REG_DATA_WIDTH   = 32
) (
  input  logic                                             clk,
  input  logic                                             rst_n,
  input  logic [EXE_UNIT_NUM-1:0]                          exe_wb_valid_i,
  input  logic [EXE_UNIT_NUM-1:0][PHY_REG_ID_WIDTH-1:0]    exe_wb_id_i,
  input  logic [EXE_UNIT_NUM-1:0][REG_DATA_WIDTH-1:0]      exe_wb_data_i,
  output logic [EXE_UNIT_NUM-1:0]                          wb_exe_ready_o,
  input  logic                                             commit_wb_flush_i,
  output logic [WB_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]        wb_phyf_id_o,
  output logic [WB_WIDTH-1:0][REG_DATA_WIDTH-1:0]          wb_phyf_data_o,
  output logic [WB_WIDTH-1:0]                              wb_phyf_we_o,
  output logic                                             wb_pending_o
);

  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned UNIT_W = (EXE_UNIT_NUM > 1) ? $clog2(EXE_UNIT_NUM) : 1;
  localparam int unsigned SUM_W  = UNIT_W + 1;
  localparam int unsigned LANE_W = (WB_WIDTH > 1) ? $clog2(WB_WIDTH) : 1;
  localparam int unsigned LCNT_W = LANE_W + 1;

  typedef struct packed {
    logic [PHY_REG_ID_WIDTH-1:0] id;
    logic [REG_DATA_WIDTH-1:0]   data;
  } wb_entry_t;

  wb_entry_t [EXE_UNIT_NUM-1:0][FIFO_DEPTH-1:0] mem_q;
  logic [EXE_UNIT_NUM-1:0][PTR_W-1:0]           wr_ptr_q, wr_ptr_d;
  logic [EXE_UNIT_NUM-1:0][PTR_W-1:0]           rd_ptr_q, rd_ptr_d;
  logic [EXE_UNIT_NUM-1:0][CNT_W-1:0]           count_q, count_d;
  logic [UNIT_W-1:0]                            rr_ptr_q, rr_ptr_d;
  logic [WB_WIDTH-1:0]                          we_q, we_d;
  logic [WB_WIDTH-1:0][PHY_REG_ID_WIDTH-1:0]    lane_id_q, lane_id_d;
  logic [WB_WIDTH-1:0][REG_DATA_WIDTH-1:0]      lane_data_q, lane_data_d;

  logic [EXE_UNIT_NUM-1:0] nonempty;
  logic [EXE_UNIT_NUM-1:0] ready;
  logic [EXE_UNIT_NUM-1:0] push;
  logic [EXE_UNIT_NUM-1:0] grant;

  // Ready comes from registered occupancy only, so a full FIFO popped this cycle stays not-ready.
  always_comb begin
    nonempty = '0;
    ready    = '0;
    for (int unsigned u = 0; u < EXE_UNIT_NUM; u++) begin
      nonempty[UNIT_W'(u)] = (count_q[UNIT_W'(u)] != '0);
      ready[UNIT_W'(u)]    = rst_n & ~commit_wb_flush_i &
                             (count_q[UNIT_W'(u)] < CNT_W'(FIFO_DEPTH));
    end
  end

  assign push           = exe_wb_valid_i & ready;
  assign wb_exe_ready_o = ready;
  assign wb_pending_o   = |nonempty;

  // Rotating scan from rr_ptr_q; the k-th non-empty unit found drives lane k.
  always_comb begin
    logic [SUM_W-1:0]  sum;
    logic [UNIT_W-1:0] uidx;
    logic [LCNT_W-1:0] n_win;
    logic [LANE_W-1:0] lane;
    grant       = '0;
    we_d        = '0;
    lane_id_d   = '0;
    lane_data_d = '0;
    rr_ptr_d    = rr_ptr_q;
    n_win       = '0;
    sum         = '0;
    uidx        = '0;
    lane        = '0;
    for (int unsigned i = 0; i < EXE_UNIT_NUM; i++) begin
      sum = {1'b0, rr_ptr_q} + SUM_W'(i);
      if (sum >= SUM_W'(EXE_UNIT_NUM)) begin
        sum = sum - SUM_W'(EXE_UNIT_NUM);
      end
      uidx = sum[UNIT_W-1:0];
      if (nonempty[uidx] && (n_win < LCNT_W'(WB_WIDTH))) begin
        lane              = n_win[LANE_W-1:0];
        grant[uidx]       = 1'b1;
        we_d[lane]        = 1'b1;
        lane_id_d[lane]   = mem_q[uidx][rd_ptr_q[uidx]].id;
        lane_data_d[lane] = mem_q[uidx][rd_ptr_q[uidx]].data;
        rr_ptr_d          = (uidx == UNIT_W'(EXE_UNIT_NUM - 1)) ? '0 : uidx + UNIT_W'(1);
        n_win             = n_win + LCNT_W'(1);
      end
    end
    if (commit_wb_flush_i) begin
      we_d        = '0;
      lane_id_d   = '0;
      lane_data_d = '0;
      rr_ptr_d    = '0;
    end
  end

  // Pointer/occupancy bookkeeping; a flush empties every FIFO in one edge.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    for (int unsigned u = 0; u < EXE_UNIT_NUM; u++) begin
      if (push[UNIT_W'(u)]) begin
        wr_ptr_d[UNIT_W'(u)] = wr_ptr_q[UNIT_W'(u)] + PTR_W'(1);
      end
      if (grant[UNIT_W'(u)]) begin
        rd_ptr_d[UNIT_W'(u)] = rd_ptr_q[UNIT_W'(u)] + PTR_W'(1);
      end
      case ({push[UNIT_W'(u)], grant[UNIT_W'(u)]})
        2'b10:   count_d[UNIT_W'(u)] = count_q[UNIT_W'(u)] + CNT_W'(1);
        2'b01:   count_d[UNIT_W'(u)] = count_q[UNIT_W'(u)] - CNT_W'(1);
        default: count_d[UNIT_W'(u)] = count_q[UNIT_W'(u)];
      endcase
    end
    if (commit_wb_flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rr_ptr_q    <= '0;
      we_q        <= '0;
      lane_id_q   <= '0;
      lane_data_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rr_ptr_q    <= rr_ptr_d;
      we_q        <= we_d;
      lane_id_q   <= lane_id_d;
      lane_data_q <= lane_data_d;
    end
  end

  // Payload storage needs no reset: entries are only read while counted valid.
  always_ff @(posedge clk) begin
    for (int unsigned u = 0; u < EXE_UNIT_NUM; u++) begin
      if (push[UNIT_W'(u)]) begin
        mem_q[UNIT_W'(u)][wr_ptr_q[UNIT_W'(u)]] <= '{id:   exe_wb_id_i[UNIT_W'(u)],
                                                      data: exe_wb_data_i[UNIT_W'(u)]};
      end
    end
  end

  assign wb_phyf_we_o   = we_q;
  assign wb_phyf_id_o   = lane_id_q;
  assign wb_phyf_data_o = lane_data_q;

endmodule
